// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: valid/ready word intake, one-word holding buffer, one bit per clock on dout.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
module serial_frame_tx #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     hold_buf, hold_buf_next, ordered;
  logic                 hold_full, hold_full_next;
  logic [FRAME_LEN-1:0] shreg, shreg_next, load_vec;
  logic [CW-1:0]        cnt, cnt_next;
  logic                 dout_next, dout_valid_next, frame_done_next, load;
`ifdef SER_PARITY_EN
  logic                 hold_par, hold_par_next;
`endif

  // Arrange the buffered word in transmit order; load_vec's top bit goes out first.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ordered[WIDTH-1-i] = MSB_FIRST ? hold_buf[WIDTH-1-i] : hold_buf[i];
    end
`ifdef SER_PARITY_EN
    load_vec = {ordered, hold_par};
`else
    load_vec = ordered;
`endif
  end

  // Next-state, buffer and output computation.
  always_comb begin
    state_next      = state;
    hold_buf_next   = hold_buf;
    hold_full_next  = hold_full;
    shreg_next      = shreg;
    cnt_next        = cnt;
    dout_next       = IDLE_LEVEL;
    dout_valid_next = 1'b0;
    frame_done_next = 1'b0;
    load            = 1'b0;
`ifdef SER_PARITY_EN
    hold_par_next   = hold_par;
`endif
    case (state)
      IDLE: begin
        if (hold_full) begin
          load = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          dout_next       = shreg[FRAME_LEN-1];
          shreg_next      = {shreg[FRAME_LEN-2:0], 1'b0};
          cnt_next        = cnt - CW'(1);
          dout_valid_next = 1'b1;
          frame_done_next = (cnt == CW'(1));
        end else if (hold_full) begin
          load = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Reload path shared by IDLE start and gapless back-to-back continuation.
    if (load) begin
      state_next      = SHIFT;
      dout_next       = load_vec[FRAME_LEN-1];
      shreg_next      = {load_vec[FRAME_LEN-2:0], 1'b0};
      cnt_next        = CW'(FRAME_LEN - 1);
      dout_valid_next = 1'b1;
      hold_full_next  = 1'b0;
    end else begin
      hold_full_next  = hold_full;
    end

    // data_ready mirrors ~hold_full, so an accept never coincides with a drain.
    if (data_valid && data_ready) begin
      hold_buf_next  = data_in;
      hold_full_next = 1'b1;
`ifdef SER_PARITY_EN
      hold_par_next  = even_parity(data_in);
`endif
    end else begin
      hold_buf_next  = hold_buf;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_buf   <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
`ifdef SER_PARITY_EN
      hold_par   <= 1'b0;
`endif
    end else begin
      hold_buf   <= hold_buf_next;
      hold_full  <= hold_full_next;
      shreg      <= shreg_next;
      cnt        <= cnt_next;
      dout       <= dout_next;
      dout_valid <= dout_valid_next;
      frame_done <= frame_done_next;
      data_ready <= ~hold_full_next;
      busy       <= (state_next == SHIFT) | hold_full_next;
`ifdef SER_PARITY_EN
      hold_par   <= hold_par_next;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: each accepted word is expanded into timed expected bits;
// a negedge monitor pops and compares them against dout/dout_valid/frame_done.
module tb_serial_frame_tx;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready, dout, dout_valid, frame_done, busy;
  logic [W-1:0] din_l = '0;
  logic         dv_l = 1'b0;
  logic         dr_l, do_l, dov_l, fd_l, busy_l;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .dout(dout), .dout_valid(dout_valid), .frame_done(frame_done), .busy(busy));

  serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(din_l), .data_valid(dv_l), .data_ready(dr_l),
    .dout(do_l), .dout_valid(dov_l), .frame_done(fd_l), .busy(busy_l));

  typedef struct {logic b; logic last; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, failures = 0, cyc = 0, last_end = -1, bits_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the line is a single serial resource; a word accepted at edge k starts
  // at the later of edge k+1 and the edge after the previous frame's last bit.
  function automatic void model_push(input logic [W-1:0] w, input int k);
    int start;
    start = (k + 1 > last_end + 1) ? k + 1 : last_end + 1;
    for (int i = 0; i < W; i++) exp_q.push_back('{w[W-1-i], (i == FL-1), start + i});
`ifdef SER_PARITY_EN
    exp_q.push_back('{^w, 1'b1, start + W});
`endif
    last_end = start + FL - 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every cycle, either against a due expected bit or against a quiet line.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      chk("bit_valid", {31'd0, dout_valid}, 32'd1);
      chk("bit_value", {31'd0, dout}, {31'd0, mon_e.b});
      chk("bit_frame_done", {31'd0, frame_done}, {31'd0, mon_e.last});
      if (dout_valid) bits_seen++;
    end else begin
      chk("idle_valid", {31'd0, dout_valid}, 32'd0);
      chk("idle_level", {31'd0, dout}, 32'd0);
      chk("idle_frame_done", {31'd0, frame_done}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    data_in = w;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("send_accept", {31'd0, data_ready}, 32'd1);
    if (data_ready === 1'b1) model_push(w, cyc + 1);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    repeat (2) tick();
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] lw;
    int n;
    // Reset held while data_valid toggles.
    for (int i = 0; i < 3; i++) begin
      tick();
      data_valid = (i % 2 == 0);
      data_in = W'($urandom);
      chk("rst_dout", {31'd0, dout}, 32'd0);
      chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, data_ready}, 32'd0);
    end
    data_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, data_ready}, 32'd1);

    send(8'hB0);
    chk("busy_single", {31'd0, busy}, 32'd1);
    drain();

    send(8'hA5);
    send(8'h3C);
    chk("b2b_ready_low", {31'd0, data_ready}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    drain();

    // LSB-first instance, directed.
    lw = 8'h01;
    chk("lsb_ready", {31'd0, dr_l}, 32'd1);
    din_l = lw;
    dv_l = 1'b1;
    tick();
    dv_l = 1'b0;
    for (int i = 0; i < FL; i++) begin
      tick();
      chk("lsb_valid", {31'd0, dov_l}, 32'd1);
      chk("lsb_bit", {31'd0, do_l}, {31'd0, (i < W) ? lw[i] : ^lw});
      chk("lsb_frame_done", {31'd0, fd_l}, {31'd0, (i == FL-1)});
    end
    tick();
    chk("lsb_idle", {31'd0, dov_l}, 32'd0);

    // Randomized words with random gaps, including back-to-back runs.
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 3);
      repeat (n) tick();
      send(W'($urandom));
    end
    drain();

    // Reset after the third bit of 8'hFF with a second word buffered.
    bits_seen = 0;
    send(8'hFF);
    send(8'h5A);
    n = 0;
    while (bits_seen < 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_bits_seen", bits_seen, 32'd3);
    rst = 1'b0;
    exp_q.delete();
    last_end = -1;
    #1;
    chk("mid_rst_dout", {31'd0, dout}, 32'd0);
    chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, data_ready}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_ready", {31'd0, data_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial framer upstream of the sequence detector; its dout drives the detector's din directly.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts one bit per clock onto dout.
- A one-word holding buffer in front of the shift register lets consecutive words stream with no idle bit between them.
- Drives IDLE_LEVEL on dout when it has nothing to send, so a downstream detector sampling every clock sees only a quiet line.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 first.
- IDLE_LEVEL, 0, value driven on dout while no frame is in progress.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  parallel word to send.
- data_valid  in  1  data_in is valid this cycle.
- data_ready  out  1  holding buffer can accept a word.
- dout  out  1  serial bit stream to the detector's din.
- dout_valid  out  1  dout carries a frame bit this cycle.
- frame_done  out  1  one-cycle pulse coincident with the last bit of a frame.
- busy  out  1  shift register active or holding buffer occupied.

Behaviour:
- Reset (rst=0, asynchronous):
  - hold_full=0, state=IDLE, bit counter=0, shift register=0.
  - dout=IDLE_LEVEL, dout_valid=0, frame_done=0, busy=0.
  - data_ready is forced 0 while rst=0.
- Reset mid-frame aborts the frame immediately. The partial word and any buffered word are discarded. Nothing resumes after reset.
- Handshake:
  - Transfer occurs on a rising edge where data_valid=1 and data_ready=1.
  - data_ready = ~hold_full, driven from a register, so it is glitch-free.
  - data_in is captured into the holding buffer at that edge and hold_full is set.
  - data_valid with data_ready=0 has no effect. The source holds data_in until accepted.
- States:
  - IDLE: dout=IDLE_LEVEL, dout_valid=0. If hold_full=1 at an edge, load the shift register from the buffer, clear hold_full, set counter=FRAME_LEN-1, go to SHIFT.
  - SHIFT: each edge advances to the next bit and decrements the counter. dout_valid=1.
  - When the counter reaches 0 (last bit on dout), frame_done=1 for that cycle.
  - At the following edge: if hold_full=1, reload from the buffer and stay in SHIFT (no gap bit). Otherwise go to IDLE.
- FRAME_LEN = WIDTH, or WIDTH+1 with parity enabled (see Optional Feature).
- Latency: word accepted at edge k while IDLE with an empty buffer → first bit on dout after edge k+1. The last bit is on dout after edge k+FRAME_LEN.
- dout, dout_valid and frame_done are all registered outputs.
- Simultaneous drain and offer: when the buffer is emptied into the shift register at edge k, data_ready is 0 during the cycle before edge k. A new word offered then is accepted at edge k+1 at the earliest.
  - Because FRAME_LEN ≥ 2, sustained back-to-back streaming still loses no bits.
- busy = (state==SHIFT) | hold_full.
- Bit order follows MSB_FIRST. Shifting is a logical shift, so no bits wrap around. The counter never underflows because the reload or the exit to IDLE happens at 0.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits) is appended after the last data bit, so FRAME_LEN=WIDTH+1.
  - frame_done is asserted on the parity bit, not on the last data bit.
  - Parity is computed when the word is captured into the holding buffer.
- Undefined: no parity logic is present, FRAME_LEN=WIDTH, and the port list is unchanged.

Test Plan:
- Reset check: hold rst=0 for 3 cycles while toggling data_valid → dout=0, dout_valid=0, busy=0, data_ready=0 throughout. data_ready=1 on the first cycle after release.
- Single word (WIDTH=8, MSB_FIRST=1): send 8'hB0 → dout=1,0,1,1,0,0,0,0 on 8 consecutive cycles starting one cycle after acceptance. frame_done on the 8th bit. The detector output pulses once. Then dout=0 and dout_valid=0.
- Back-to-back: hold data_valid=1 with 8'hA5, then 8'h3C → 16 contiguous dout_valid cycles with no gap bit. data_ready drops while the buffer is full.
- Bit order: MSB_FIRST=0, send 8'h01 → dout=1 on the first bit cycle, then seven 0s.
- Reset mid-frame: assert rst after the 3rd bit of 8'hFF with a second word buffered → dout=0 and busy=0 immediately. No remaining bits appear after release.
- SER_PARITY_EN defined: send 8'h07 → 8 data bits, then parity bit 1. frame_done on cycle 9. Sending 8'h03 gives parity bit 0.
